// File: rtl/pwm_pkg.sv
// Register map and shared constants for the multi-channel PWM peripheral.
package pwm_pkg;

   localparam int MAX_CH = 16;

   localparam logic [7:0] CTRL      = 8'h00;
   localparam logic [7:0] POL       = 8'h01;
   localparam logic [7:0] IEN       = 8'h02;
   localparam logic [7:0] STS       = 8'h03;
   localparam logic [7:0] PER_BASE  = 8'h20;
   localparam logic [7:0] DUTY_BASE = 8'h40;
   localparam logic [7:0] CNT_BASE  = 8'h60;

   // True when sel addresses the per-channel register at base + n.
   function automatic logic chan_hit(input logic [7:0] sel, input logic [7:0] base,
                                     input int n);
      return sel == (base + 8'(n));
   endfunction

endpackage

// File: rtl/pwm_chan.sv
// One PWM channel with shadowed period/duty, loaded into the active copy at wrap.
// Latency: counter to pin one cycle; backpressure: none, writes always accepted.
module pwm_chan #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             pol,
   input  logic [CNT_W-1:0] wr_dat,
   input  logic             per_wr,
   input  logic             duty_wr,
   output logic             pw,
   output logic             wrap,
   output logic [CNT_W-1:0] cnt,
   output logic [CNT_W-1:0] per_sh,
   output logic [CNT_W-1:0] duty_sh
);

   localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [CNT_W-1:0] per_act;
   logic [CNT_W-1:0] duty_act;
   logic             run;

   assign run  = en && (per_act != '0);
   // >= rather than == so a period shrunk below cnt still wraps.
   assign wrap = run && (cnt >= per_act - ONE);

   always_ff @(posedge clk) begin
      if (!rst) begin
         per_sh   <= '0;
         duty_sh  <= '0;
         per_act  <= '0;
         duty_act <= '0;
         cnt      <= '0;
         pw       <= 1'b0;
      end else begin
         if (per_wr)  per_sh  <= wr_dat;
         if (duty_wr) duty_sh <= wr_dat;

         if (!run || wrap) begin
            per_act  <= per_sh;
            duty_act <= duty_sh;
         end

         if (!run) begin
            cnt <= '0;
            pw  <= pol;
         end else begin
            cnt <= wrap ? '0 : cnt + ONE;
            pw  <= pol ^ (cnt < duty_act);
         end
      end
   end

endmodule

// File: rtl/pwm_multi.sv
// Memory-mapped N-channel PWM: register decode, status/irq and readback around pwm_chan.
// Latency: writes take effect next edge, irq one cycle after STS; backpressure: none.
module pwm_multi
   import pwm_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int CNT_W  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we_i,
   input  logic [31:0]       addr_i,
   input  logic [31:0]       data_i,
   output logic [31:0]       data_o,
   output logic [NUM_CH-1:0] pw_o,
   output logic              irq_o
);

   logic [7:0]        sel;
   logic [CNT_W-1:0]  wr_dat;
   logic [NUM_CH-1:0] ctrl_r;
   logic [NUM_CH-1:0] pol_r;
   logic [NUM_CH-1:0] ien_r;
   logic [NUM_CH-1:0] sts_r;
   logic [NUM_CH-1:0] sts_clr;
   logic [NUM_CH-1:0] wrap;
   logic [CNT_W-1:0]  cnt     [NUM_CH];
   logic [CNT_W-1:0]  per_sh  [NUM_CH];
   logic [CNT_W-1:0]  duty_sh [NUM_CH];
   logic              unused_bits;

   assign sel         = addr_i[23:16];
   assign wr_dat      = data_i[CNT_W-1:0];
   assign unused_bits = ^{addr_i[31:24], addr_i[15:0], data_i};

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      pwm_chan #(.CNT_W(CNT_W)) u_chan (
         .clk     (clk),
         .rst     (rst),
         .en      (ctrl_r[g]),
         .pol     (pol_r[g]),
         .wr_dat  (wr_dat),
         .per_wr  (we_i && chan_hit(sel, PER_BASE, g)),
         .duty_wr (we_i && chan_hit(sel, DUTY_BASE, g)),
         .pw      (pw_o[g]),
         .wrap    (wrap[g]),
         .cnt     (cnt[g]),
         .per_sh  (per_sh[g]),
         .duty_sh (duty_sh[g])
      );
   end

   assign sts_clr = (we_i && sel == STS) ? data_i[NUM_CH-1:0] : '0;

   always_ff @(posedge clk) begin
      if (!rst) begin
         ctrl_r <= '0;
         pol_r  <= '0;
         ien_r  <= '0;
         sts_r  <= '0;
         irq_o  <= 1'b0;
      end else begin
         if (we_i && sel == CTRL) ctrl_r <= data_i[NUM_CH-1:0];
         if (we_i && sel == POL)  pol_r  <= data_i[NUM_CH-1:0];
         if (we_i && sel == IEN)  ien_r  <= data_i[NUM_CH-1:0];
         // A wrap in the same cycle as a clear keeps the flag set.
         sts_r <= (sts_r & ~sts_clr) | wrap;
         irq_o <= |(sts_r & ien_r);
      end
   end

   always_comb begin
      data_o = '0;
      if (rst) begin
         case (sel)
            CTRL:    data_o = 32'(ctrl_r);
            POL:     data_o = 32'(pol_r);
            IEN:     data_o = 32'(ien_r);
            STS:     data_o = 32'(sts_r);
            default: data_o = '0;
         endcase
         for (int i = 0; i < NUM_CH; i++) begin
            if (chan_hit(sel, PER_BASE, i))  data_o = 32'(per_sh[i]);
            if (chan_hit(sel, DUTY_BASE, i)) data_o = 32'(duty_sh[i]);
            if (chan_hit(sel, CNT_BASE, i))  data_o = 32'(cnt[i]);
         end
      end
   end

endmodule

// File: doc/pwm_multi.md
Name: pwm_multi

Overview:
- Memory-mapped, parametrised multi-channel PWM generator on the peripheral bus; a successor to the fixed 4-channel PWM.
- Adds the following over that block:
  - N channels with configurable counter width.
  - Shadowed period/duty registers, loaded only at period wrap, so there are no glitches on reprogramming.
  - Per-channel enable and output polarity.
  - Period-wrap status flags with a maskable interrupt.
- Register select is `addr_i[23:16]`; the bus decoder owns the upper bits.

Parameters:
- NUM_CH, 4, number of channels (1..16).
- CNT_W, 32, width of the counter, period and duty registers (8..32).

Ports:
- clk  in  1  system clock
- rst  in  1  reset; one clock, reset is synchronous and active-low
- we_i  in  1  register write strobe, single cycle
- addr_i  in  32  byte address; `[23:16]` selects the register
- data_i  in  32  write data
- data_o  out  32  read data, combinational
- pw_o  out  NUM_CH  PWM outputs, registered
- irq_o  out  1  level interrupt

Behaviour:
- Register map, `addr_i[23:16]`:
  - 8'h00 CTRL: bit n = channel n enable.
  - 8'h01 POL: bit n = 1 inverts pw_o[n].
  - 8'h02 IEN: interrupt mask.
  - 8'h03 STS: wrap flags; write 1 clears.
  - 8'h20+n PERIOD_n shadow.
  - 8'h40+n DUTY_n shadow.
  - 8'h60+n CNT_n, read-only.
  - Writes with n >= NUM_CH, and writes to unmapped addresses, are ignored.
- Read path:
  - Unmapped reads return 0; data_o = 0 while rst = 0.
  - PERIOD/DUTY reads return the shadow value, zero-extended from CNT_W.
  - Write data is truncated to CNT_W.
- Reset (rst = 0 at posedge): every register, shadow, active copy, counter, STS and IEN goes to 0; pw_o = 0; irq_o = 0.
  - Reset mid-period aborts the period immediately.
- Each channel keeps an active copy of period P and duty D, plus a counter cnt.
- Disabled (CTRL[n] = 0):
  - cnt <= 0 and pw_o[n] <= POL[n].
  - Active copy <= shadow every cycle.
- Idle (enabled, active P = 0): same as disabled. The output is at its inactive level and no STS is set.
- Running (enabled, P > 0):
  - If cnt >= P-1: cnt <= 0, active P/D <= shadow, STS[n] <= 1 (wrap). Otherwise cnt <= cnt+1.
  - pw_o[n] <= POL[n] ^ (cnt < D), using the current cnt and active D. This gives one cycle of latency from counter to pin.
  - Waveform: high for D of every P cycles.
  - D = 0 gives constant inactive; D >= P gives constant active.
- Enable edge:
  - First enabled cycle: cnt = 0, active copy = latest shadow.
  - The first pw_o active level appears on the next cycle.
- Disable mid-period: takes effect on the next edge; the output goes inactive and no STS is set.
- Write to PERIOD_n/DUTY_n in a wrap cycle: the active copy loads the pre-write shadow value. The new value applies at the following wrap, or immediately if the channel is disabled or idle.
- STS write-1-clear in the same cycle as a wrap on that channel: set wins, so the flag stays 1.
- irq_o is registered: irq_o <= |(STS & IEN), one cycle after the flag.
- Counter comparisons are unsigned. If P is lowered below cnt via the active copy, the `>=` compare forces a wrap, so there is no counter run-away.

Decomposition:
- Package pwm_pkg holds:
  - Register offset constants: CTRL, POL, IEN, STS, PER_BASE, DUTY_BASE, CNT_BASE.
  - MAX_CH = 16.
- Sub-module pwm_chan holds one channel:
  - Inputs: en, pol, shadow P/D, shadow write strobes.
  - Outputs: pw, wrap pulse, cnt.
- The top level owns decode, the CTRL/POL/IEN/STS registers, the readback mux and irq. pwm_chan is generated NUM_CH times.

Test Plan:
- Basic waveform: reset, write PERIOD_0 = 4, DUTY_0 = 1, CTRL = 1 -> pw_o[0] repeats 1,0,0,0 starting 2 cycles after the CTRL write; STS[0] sets every 4 cycles.
- Polarity and duty extremes on ch1, P = 5:
  - POL = 2, D = 2 -> pattern 0,0,1,1,1.
  - D = 0 -> constant 1.
  - D = 7 -> constant 0.
  - P = 0 with CTRL set -> constant 1 (inactive inverted level), STS[1] never sets.
- Shadow: running P = 10, D = 3; write DUTY_0 = 8 at cnt = 5 -> the current period keeps 3 high cycles and the next period shows 8; read DUTY_0 returns 8 immediately.
- Status and interrupt: IEN = 1, wait for a wrap -> irq_o = 1 one cycle after STS[0]; write STS = 1 -> irq_o drops, unless the write coincides with a wrap, in which case STS stays 1.
- Reset mid-operation: rst = 0 at cnt = 3 with all channels running -> on the next edge all pw_o = 0, CNT reads 0, data_o = 0 during reset, CTRL = 0 after.
- Parameter sweep: NUM_CH = 1, CNT_W = 8; write PERIOD_0 = 32'h1FF -> reads 8'hFF, period 255; writes to 8'h21 are ignored and read back 0.
